// File: rtl/multicycle_controlunit.sv
// Multicycle RV32I control unit: a registered FSM that sequences fetch, decode,
// execute, memory and writeback over a shared-ALU, shared-memory datapath.
module multicycle_controlunit #(
   parameter int DATA_WIDTH = 32,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  EQ,
   input  logic                  LT,
   input  logic                  LTU,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  MemWrite,
   output logic                  AdrSrc,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  RegWrite,
   output logic [1:0]            ALUsrcA,
   output logic [1:0]            ALUsrcB,
   output logic [2:0]            ImmSrc,
   output logic [ALU_CTRL_W-1:0] ALUctrl,
   output logic [1:0]            ResultSrc,
   output logic                  instr_done,
   output logic                  illegal,
   output logic [3:0]            state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LINK     = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(5);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(6);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(7);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(8);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(9);
   localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(10);

   state_t                r_state;
   state_t                w_next;
   logic [6:0]            w_opcode;
   logic [2:0]            w_funct3;
   logic                  w_f7b5;
   logic                  w_unused;
   logic                  w_mem_req;
   logic                  w_mem_write;
   logic                  w_adr_src;
   logic                  w_ir_write;
   logic                  w_pc_write;
   logic                  w_reg_write;
   logic [1:0]            w_alu_a;
   logic [1:0]            w_alu_b;
   logic [2:0]            w_imm_src;
   logic [ALU_CTRL_W-1:0] w_alu_ctrl;
   logic [1:0]            w_result;
   logic                  w_illegal;
   logic                  w_done;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_f7b5   = instr[30];
   assign w_unused = ^instr;

   function automatic logic [ALU_CTRL_W-1:0] alu_decode(input logic f7b5, input logic [2:0] f3);
      case (f3)
         3'b000:  return f7b5 ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [2:0] imm_decode(input logic [6:0] op);
      case (op)
         OP_STORE:  return 3'b001;
         OP_BRANCH: return 3'b010;
         OP_JAL:    return 3'b011;
         OP_LUI:    return 3'b100;
         default:   return 3'b000;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves one unassigned and infers a latch.
      w_next      = r_state;
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_adr_src   = 1'b0;
      w_ir_write  = 1'b0;
      w_pc_write  = 1'b0;
      w_reg_write = 1'b0;
      w_alu_a     = 2'b00;
      w_alu_b     = 2'b00;
      w_imm_src   = imm_decode(w_opcode);
      w_alu_ctrl  = ALU_ADD;
      w_result    = 2'b00;
      w_illegal   = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            w_alu_b   = 2'b10;
            w_result  = 2'b10;
            if (mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively form PC-relative target in ALUOut for branch/JAL.
            w_alu_a = 2'b01;
            w_alu_b = 2'b01;
            case (w_opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_R:              w_next = S_EXECR;
               OP_I:              w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = (w_funct3 == 3'b000) ? S_JALR : S_TRAP;
               OP_LUI:            w_next = S_LUI;
               default:           w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            w_alu_a = 2'b10;
            w_alu_b = 2'b01;
            w_next  = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_result    = 2'b01;
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXECR: begin
            w_alu_a    = 2'b10;
            w_alu_ctrl = alu_decode(w_f7b5, w_funct3);
            w_next     = S_ALUWB;
         end
         S_EXECI: begin
            // Bit 30 is part of the immediate except for shift-right forms.
            w_alu_a    = 2'b10;
            w_alu_b    = 2'b01;
            w_alu_ctrl = alu_decode(w_f7b5 & (w_funct3 == 3'b101), w_funct3);
            w_next     = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_a    = 2'b10;
            w_alu_ctrl = ALU_SUB;
            w_next     = S_FETCH;
            case (w_funct3)
               3'b000:  w_pc_write = EQ;
               3'b001:  w_pc_write = ~EQ;
               3'b100:  w_pc_write = LT;
               3'b101:  w_pc_write = ~LT;
               3'b110:  w_pc_write = LTU;
               3'b111:  w_pc_write = ~LTU;
               default: w_next     = S_TRAP;
            endcase
         end
         S_JAL: begin
            w_pc_write = 1'b1;
            w_alu_a    = 2'b01;
            w_alu_b    = 2'b10;
            w_next     = S_ALUWB;
         end
         S_JALR: begin
            w_alu_a    = 2'b10;
            w_alu_b    = 2'b01;
            w_result   = 2'b10;
            w_pc_write = 1'b1;
            w_next     = S_LINK;
         end
         S_LINK: begin
            w_alu_a = 2'b01;
            w_alu_b = 2'b10;
            w_next  = S_ALUWB;
         end
         S_LUI: begin
            w_imm_src  = 3'b100;
            w_alu_b    = 2'b01;
            w_alu_ctrl = ALU_PASSB;
            w_next     = S_ALUWB;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
         end
         default: w_next = S_TRAP;
      endcase

      w_done = (w_next == S_FETCH) && (r_state != S_FETCH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is registered with non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Reset gates the combinational outputs so nothing requests or writes while rst_n is low.
   assign mem_req    = rst_n & w_mem_req;
   assign MemWrite   = rst_n & w_mem_write;
   assign AdrSrc     = rst_n & w_adr_src;
   assign IRWrite    = rst_n & w_ir_write;
   assign PCWrite    = rst_n & w_pc_write;
   assign RegWrite   = rst_n & w_reg_write;
   assign ALUsrcA    = rst_n ? w_alu_a    : 2'b00;
   assign ALUsrcB    = rst_n ? w_alu_b    : 2'b00;
   assign ImmSrc     = rst_n ? w_imm_src  : 3'b000;
   assign ALUctrl    = rst_n ? w_alu_ctrl : '0;
   assign ResultSrc  = rst_n ? w_result   : 2'b00;
   assign instr_done = rst_n & w_done;
   assign illegal    = rst_n & w_illegal;
   assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for multicycle_controlunit: walks each instruction class through
// its state sequence and compares every control output against hand-derived values.
module tb_multicycle_controlunit;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_LINK     = 4'd12;
   localparam logic [3:0] S_LUI      = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd14;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        EQ, LT, LTU, mem_ready;
   logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0]  ALUsrcA, ALUsrcB, ResultSrc;
   logic [2:0]  ImmSrc;
   logic [3:0]  ALUctrl;
   logic        instr_done, illegal;
   logic [3:0]  state_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int c0;

   // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, illegal}
   logic [7:0] w_en;
   assign w_en = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, illegal};

   multicycle_controlunit #(.DATA_WIDTH(32), .ALU_CTRL_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .LT(LT), .LTU(LTU),
      .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA),
      .ALUsrcB(ALUsrcB), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .ResultSrc(ResultSrc),
      .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] st, input logic [7:0] en,
                       input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                       input logic [1:0] rs);
      #1;
      check({tag, ".state"},  32'(state_o),   32'(st));
      check({tag, ".enables"}, 32'(w_en),     32'(en));
      check({tag, ".srcA"},   32'(ALUsrcA),   32'(a));
      check({tag, ".srcB"},   32'(ALUsrcB),   32'(b));
      check({tag, ".aluctl"}, 32'(ALUctrl),   32'(alu));
      check({tag, ".result"}, 32'(ResultSrc), 32'(rs));
   endtask

   task automatic go();
      @(negedge clk);
   endtask

   task automatic fetch_decode(input string tag, input logic [31:0] ins, input logic [2:0] imm);
      instr     = ins;
      mem_ready = 1'b1;
      step({tag, ".fetch"}, S_FETCH, 8'b1001_1000, 2'd0, 2'd2, 4'd0, 2'd2);
      go();
      step({tag, ".decode"}, S_DECODE, 8'b0000_0000, 2'd1, 2'd1, 4'd0, 2'd0);
      check({tag, ".decode.imm"}, 32'(ImmSrc), 32'(imm));
      go();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; instr = 32'h00500093;
      EQ = 1'b0; LT = 1'b0; LTU = 1'b0; mem_ready = 1'b1;
      step("reset", S_FETCH, 8'b0000_0000, 2'd0, 2'd0, 4'd0, 2'd0);
      check("reset.imm", 32'(ImmSrc), 32'd0);
      go();
      rst_n = 1'b1;

      // addi x1,x0,5: FETCH, DECODE, EXECI, ALUWB
      c0 = cyc;
      fetch_decode("addi", 32'h00500093, 3'd0);
      step("addi.execi", S_EXECI, 8'b0000_0000, 2'd2, 2'd1, 4'd0, 2'd0);
      go();
      step("addi.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();
      #1 check("addi.latency", 32'(cyc - c0), 32'd4);

      // bne taken (EQ=0) and not taken (EQ=1)
      EQ = 1'b0;
      fetch_decode("bne_t", 32'h00209463, 3'd2);
      step("bne_t.branch", S_BRANCH, 8'b0000_1010, 2'd2, 2'd0, 4'd1, 2'd0);
      go();
      EQ = 1'b1;
      fetch_decode("bne_nt", 32'h00209463, 3'd2);
      step("bne_nt.branch", S_BRANCH, 8'b0000_0010, 2'd2, 2'd0, 4'd1, 2'd0);
      go();
      EQ = 1'b0;

      // blt follows LT, bgeu follows !LTU; flags flipped within the BRANCH cycle
      fetch_decode("blt", 32'h0020C463, 3'd2);
      LT = 1'b1;
      step("blt.taken", S_BRANCH, 8'b0000_1010, 2'd2, 2'd0, 4'd1, 2'd0);
      LT = 1'b0;
      step("blt.not_taken", S_BRANCH, 8'b0000_0010, 2'd2, 2'd0, 4'd1, 2'd0);
      go();
      fetch_decode("bgeu", 32'h0020F463, 3'd2);
      LTU = 1'b1;
      step("bgeu.not_taken", S_BRANCH, 8'b0000_0010, 2'd2, 2'd0, 4'd1, 2'd0);
      LTU = 1'b0;
      step("bgeu.taken", S_BRANCH, 8'b0000_1010, 2'd2, 2'd0, 4'd1, 2'd0);
      go();

      // lw with three wait cycles in MEMREAD
      fetch_decode("lw", 32'h0000A183, 3'd0);
      mem_ready = 1'b0;
      step("lw.memadr", S_MEMADR, 8'b0000_0000, 2'd2, 2'd1, 4'd0, 2'd0);
      go();
      for (int i = 0; i < 3; i++) begin
         step($sformatf("lw.wait%0d", i), S_MEMREAD, 8'b1010_0000, 2'd0, 2'd0, 4'd0, 2'd0);
         go();
      end
      mem_ready = 1'b1;
      step("lw.memread", S_MEMREAD, 8'b1010_0000, 2'd0, 2'd0, 4'd0, 2'd0);
      go();
      step("lw.memwb", S_MEMWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd1);
      go();

      // sw with one stalled fetch cycle
      instr = 32'h0020A223; mem_ready = 1'b0;
      step("sw.fetch_wait", S_FETCH, 8'b1000_0000, 2'd0, 2'd2, 4'd0, 2'd2);
      go();
      fetch_decode("sw", 32'h0020A223, 3'd1);
      step("sw.memadr", S_MEMADR, 8'b0000_0000, 2'd2, 2'd1, 4'd0, 2'd0);
      go();
      step("sw.memwrite", S_MEMWRITE, 8'b1110_0010, 2'd0, 2'd0, 4'd0, 2'd0);
      go();

      // ALU control decode: sub, srai, addi with bit30 set
      fetch_decode("sub", 32'h402081B3, 3'd0);
      step("sub.execr", S_EXECR, 8'b0000_0000, 2'd2, 2'd0, 4'd1, 2'd0);
      go();
      step("sub.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();
      fetch_decode("srai", 32'h4030D093, 3'd0);
      step("srai.execi", S_EXECI, 8'b0000_0000, 2'd2, 2'd1, 4'd9, 2'd0);
      go();
      step("srai.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();
      fetch_decode("addi30", 32'h40000093, 3'd0);
      step("addi30.execi", S_EXECI, 8'b0000_0000, 2'd2, 2'd1, 4'd0, 2'd0);
      go();
      step("addi30.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();

      // lui passes the U immediate through
      fetch_decode("lui", 32'h123452B7, 3'd4);
      step("lui.lui", S_LUI, 8'b0000_0000, 2'd0, 2'd1, 4'd10, 2'd0);
      check("lui.imm", 32'(ImmSrc), 32'd4);
      go();
      step("lui.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();

      // jal
      fetch_decode("jal", 32'h008000EF, 3'd3);
      step("jal.jal", S_JAL, 8'b0000_1000, 2'd1, 2'd2, 4'd0, 2'd0);
      go();
      step("jal.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();

      // jalr: JALR, LINK, ALUWB, five cycles fetch to fetch
      c0 = cyc;
      fetch_decode("jalr", 32'h000100E7, 3'd0);
      step("jalr.jalr", S_JALR, 8'b0000_1000, 2'd2, 2'd1, 4'd0, 2'd2);
      go();
      step("jalr.link", S_LINK, 8'b0000_0000, 2'd1, 2'd2, 4'd0, 2'd0);
      go();
      step("jalr.aluwb", S_ALUWB, 8'b0000_0110, 2'd0, 2'd0, 4'd0, 2'd0);
      go();
      #1 check("jalr.latency", 32'(cyc - c0), 32'd5);

      // illegal opcode traps and holds until an asynchronous reset
      fetch_decode("trap", 32'h00000000, 3'd0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("trap.hold%0d", i), S_TRAP, 8'b0000_0001, 2'd0, 2'd0, 4'd0, 2'd0);
         go();
      end
      #2 rst_n = 1'b0;
      step("trap.async_reset", S_FETCH, 8'b0000_0000, 2'd0, 2'd0, 4'd0, 2'd0);
      go();
      rst_n = 1'b1;
      step("post_reset.fetch", S_FETCH, 8'b1001_1000, 2'd0, 2'd2, 4'd0, 2'd2);
      go();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Parametrised multicycle successor to the single-cycle control unit. A registered FSM sequences each RV32I instruction through fetch, decode, execute, memory and writeback states, driving a shared-ALU, shared-memory datapath. It supports R/I-type ALU ops, loads/stores, all six branches, JAL, JALR and LUI, and waits on a memory ready handshake. It sits beside the datapath; the instruction register (IR) is held in the datapath and fed back on `instr`.

## Interface
- DATA_WIDTH, 32, instruction width (only [31:0] decoded)
- ALU_CTRL_W, 4, ALUctrl width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  DATA_WIDTH  current IR contents
- EQ, LT, LTU  in  1 each  ALU compare flags (rs1==rs2, signed <, unsigned <)
- mem_ready  in  1  memory completes request this cycle
- mem_req  out  1  memory request
- MemWrite  out  1  store
- AdrSrc  out  1  0=PC, 1=ALUOut
- IRWrite, PCWrite, RegWrite  out  1 each  register enables
- ALUsrcA  out  2  00=PC, 01=oldPC, 10=rs1
- ALUsrcB  out  2  00=rs2, 01=imm, 10=const 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUctrl  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB
- ResultSrc  out  2  00=ALUOut reg, 01=read data, 10=ALU result direct
- instr_done  out  1  one-cycle pulse on instruction retire
- illegal  out  1  sticky, in TRAP
- state_o  out  4  current state encoding

## Operation
- Default per cycle, unless the state says otherwise: all enables 0, selects 0, ALUctrl add, ImmSrc from opcode (I for unlisted opcodes).
- FETCH: mem_req=1, AdrSrc=0, ALUsrcA=00, ALUsrcB=10, ResultSrc=10. Stays until mem_ready. On mem_ready: IRWrite=1, PCWrite=1, then DECODE.
- DECODE: ALUsrcA=01, ALUsrcB=01, add (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011, 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 (funct3 000) -> JALR
  - 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: ALUsrcA=10, ALUsrcB=01, add. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Waits for mem_ready, then FETCH.
- EXECR: A=rs1, B=rs2. ALUctrl from {funct7[5], funct3}: add/sub, sll, slt, sltu, xor, srl/sra, or, and. Then ALUWB.
- EXECI: A=rs1, B=imm. Same mapping; funct7[5] is honoured only for funct3=101 (addi never subtracts). Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=rs1, B=rs2, sub, ResultSrc=00. PCWrite=taken, where funct3 selects: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU. Then FETCH. funct3 010/011 -> TRAP with no PCWrite.
- JAL: ResultSrc=00, PCWrite=1, A=oldPC, B=4, add (link into ALUOut). Then ALUWB.
- JALR: A=rs1, B=imm, add, ResultSrc=10, PCWrite=1. Then LINK.
- LINK: A=oldPC, B=4, add. Then ALUWB.
- LUI: ImmSrc=100, ALUsrcB=01, passB. Then ALUWB.
- TRAP: illegal=1, all enables 0. Held until reset.
- instr_done=1 in any cycle whose next state is FETCH from a non-FETCH state.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH. While rst_n is low, all outputs are forced to 0, mem_req included; illegal clears.
- First mem_req is asserted in the first cycle after rst_n deasserts.
- Reset mid-operation abandons any outstanding memory request. No write-enable may assert while rst_n is low.
- Outputs are Moore plus condition: combinational from the state register, instr, flags and mem_ready. State registers on the rising edge.
- Latencies with zero-wait memory (fetch to next fetch):
  - ALU, LUI: 4 cycles
  - branch: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles
- Each cycle mem_ready stays low adds exactly one cycle in FETCH/MEMREAD/MEMWRITE, with outputs held stable.
- mem_ready outside memory states is ignored.
- instr must stay stable from DECODE through retire. IRWrite only in FETCH guarantees this.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), mem_ready tied 1 -> states FETCH, DECODE, EXECI, ALUWB. RegWrite=1 in cycle 4, instr_done pulses in cycle 4.
- bne with EQ=0 -> PCWrite=1 in BRANCH. With EQ=1 -> PCWrite=0. Repeat for blt/bgeu using LT/LTU.
- lw with mem_ready low 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, mem_req/AdrSrc stable, then MEMWB with ResultSrc=01, RegWrite=1.
- sub (funct7=0100000, funct3=000, op 0110011) -> ALUctrl=1. srai -> 9. addi with instr[30]=1 -> ALUctrl=0.
- Opcode 0000000 -> TRAP, illegal=1 persists 10 cycles with no enables. rst_n low asynchronously -> illegal=0, state FETCH.
- jalr -> PCWrite with ResultSrc=10 in JALR, then LINK, then RegWrite in ALUWB. Total 5 cycles.
